eth_axi_master: RTL

Single-outstanding AXI4 master that converts a simple memory-request interface (req/gnt, we, addr, be, wdata → rvalid, rdata) into single-beat AXI transactions. It performs the opposite conversion to the Ethernet block's AXI-to-memory slave adapter. The Ethernet framing logic uses it to move frame buffers and descriptors to and from system memory over the SoC AXI interconnect.

---
 rtl/eth_axi_master_if.sv | 89 ++++++++
 rtl/eth_axi_master.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/eth_axi_master_if.sv
// AXI4 bus bundle shared by the Ethernet DMA path; one master and one slave modport.
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 8,
    parameter int unsigned AXI_USER_WIDTH = 8
);
    localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;

    logic [AXI_ID_WIDTH-1:0]   aw_id;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic                      aw_lock;
    logic [3:0]                aw_cache;
    logic [2:0]                aw_prot;
    logic [3:0]                aw_qos;
    logic [3:0]                aw_region;
    logic [5:0]                aw_atop;
    logic [AXI_USER_WIDTH-1:0] aw_user;
    logic                      aw_valid;
    logic                      aw_ready;

    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0]     w_strb;
    logic                      w_last;
    logic [AXI_USER_WIDTH-1:0] w_user;
    logic                      w_valid;
    logic                      w_ready;

    logic [AXI_ID_WIDTH-1:0]   b_id;
    logic [1:0]                b_resp;
    logic [AXI_USER_WIDTH-1:0] b_user;
    logic                      b_valid;
    logic                      b_ready;

    logic [AXI_ID_WIDTH-1:0]   ar_id;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic                      ar_lock;
    logic [3:0]                ar_cache;
    logic [2:0]                ar_prot;
    logic [3:0]                ar_qos;
    logic [3:0]                ar_region;
    logic [AXI_USER_WIDTH-1:0] ar_user;
    logic                      ar_valid;
    logic                      ar_ready;

    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [AXI_USER_WIDTH-1:0] r_user;
    logic                      r_valid;
    logic                      r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_atop, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_atop, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/eth_axi_master.sv
// Single-outstanding AXI4 master: turns req/gnt memory requests into single-beat
// AXI reads and writes and reports completion with a one-cycle rvalid_o pulse.
module eth_axi_master #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 8,
    parameter int unsigned AXI_USER_WIDTH = 8,
    parameter int unsigned AXI_ID         = 0
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        req_i,
    output logic                        gnt_o,
    input  logic                        we_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   addr_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] be_i,
    input  logic [AXI_DATA_WIDTH-1:0]   wdata_i,
    output logic                        rvalid_o,
    output logic [AXI_DATA_WIDTH-1:0]   rdata_o,
    output logic                        err_o,
    AXI_BUS.Master                      master
);
    localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;
    localparam int unsigned OFFSET     = $clog2(STRB_WIDTH);
    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_MASK = {AXI_ADDR_WIDTH{1'b1}} << OFFSET;

    typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RRESP} state_e;

    state_e                    state_q, state_d;
    logic                      aw_done_q, aw_done_d;
    logic                      w_done_q, w_done_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [STRB_WIDTH-1:0]     be_q;
    logic [AXI_DATA_WIDTH-1:0] wdata_q;
    logic                      rvalid_q;
    logic                      err_q;
    logic [AXI_DATA_WIDTH-1:0] rdata_q;

    logic aw_valid, w_valid, ar_valid, b_ready, r_ready;
    logic complete, resp_err, capture_r;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        gnt_o     = 1'b0;
        aw_valid  = 1'b0;
        w_valid   = 1'b0;
        ar_valid  = 1'b0;
        b_ready   = 1'b0;
        r_ready   = 1'b0;
        complete  = 1'b0;
        resp_err  = 1'b0;
        capture_r = 1'b0;
        unique case (state_q)
            IDLE: begin
                gnt_o     = req_i;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (req_i) state_d = we_i ? WRITE : READ;
            end
            WRITE: begin
                // AW and W retire independently; the sticky flags stop a second beat.
                aw_valid = !aw_done_q;
                w_valid  = !w_done_q;
                if (aw_valid && master.aw_ready) aw_done_d = 1'b1;
                if (w_valid && master.w_ready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d)       state_d   = WRESP;
            end
            WRESP: begin
                b_ready = 1'b1;
                if (master.b_valid) begin
                    state_d  = IDLE;
                    complete = 1'b1;
                    resp_err = (master.b_resp != 2'b00);
                end
            end
            READ: begin
                ar_valid = 1'b1;
                if (master.ar_ready) state_d = RRESP;
            end
            RRESP: begin
                r_ready = 1'b1;
                if (master.r_valid) begin
                    state_d   = IDLE;
                    complete  = 1'b1;
                    capture_r = 1'b1;
                    resp_err  = (master.r_resp != 2'b00);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rvalid_q  <= complete;
            if (complete)  err_q   <= resp_err;
            if (capture_r) rdata_q <= master.r_data;
        end
    end

    // NOTE: the request payload needs no reset; it is only observed while a valid it feeds is high.
    always_ff @(posedge clk_i) begin
        if (state_q == IDLE && req_i) begin
            addr_q  <= addr_i & ADDR_MASK;
            be_q    <= be_i;
            wdata_q <= wdata_i;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;

    assign master.aw_id     = AXI_ID_WIDTH'(AXI_ID);
    assign master.aw_addr   = addr_q;
    assign master.aw_len    = 8'd0;
    assign master.aw_size   = 3'(OFFSET);
    assign master.aw_burst  = 2'b01;
    assign master.aw_lock   = 1'b0;
    assign master.aw_cache  = 4'd0;
    assign master.aw_prot   = 3'd0;
    assign master.aw_qos    = 4'd0;
    assign master.aw_region = 4'd0;
    assign master.aw_atop   = 6'd0;
    assign master.aw_user   = '0;
    assign master.aw_valid  = aw_valid;

    assign master.w_data  = wdata_q;
    assign master.w_strb  = be_q;
    assign master.w_last  = 1'b1;
    assign master.w_user  = '0;
    assign master.w_valid = w_valid;

    assign master.b_ready = b_ready;

    assign master.ar_id     = AXI_ID_WIDTH'(AXI_ID);
    assign master.ar_addr   = addr_q;
    assign master.ar_len    = 8'd0;
    assign master.ar_size   = 3'(OFFSET);
    assign master.ar_burst  = 2'b01;
    assign master.ar_lock   = 1'b0;
    assign master.ar_cache  = 4'd0;
    assign master.ar_prot   = 3'd0;
    assign master.ar_qos    = 4'd0;
    assign master.ar_region = 4'd0;
    assign master.ar_user   = '0;
    assign master.ar_valid  = ar_valid;

    assign master.r_ready = r_ready;

    // Response IDs, users and r_last carry no information for single-beat, single-ID traffic.
    logic unused_resp_fields;
    assign unused_resp_fields = ^{master.b_id, master.b_user, master.r_id, master.r_last, master.r_user};
endmodule
